// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: instruction field layout, opcode
// flag bits, and the decode/shadow record types used by the decode stage.
package cpu_pkg;

   localparam int NREGS   = 16;
   localparam int XLEN    = 32;
   localparam int REG_W   = 4;
   localparam int INSTR_W = 48;

   localparam int OP_MSB  = 47;
   localparam int RD_MSB  = 39;
   localparam int RS_MSB  = 35;
   localparam int IMM_MSB = 31;

   localparam logic [7:0] OP_NOP = 8'h00;

   localparam int OPF_NOWRITE = 7;
   localparam int OPF_READ_RD = 6;
   localparam int OPF_READ_RS = 5;

   typedef logic [REG_W-1:0] reg_id_t;

   // One in-flight writer: the register it will write once it retires.
   typedef struct packed {
      logic    valid;
      reg_id_t regnum;
   } shadow_t;

   typedef struct packed {
      logic [7:0]      op;
      reg_id_t         rd;
      reg_id_t         rs;
      logic [XLEN-1:0] imm;
      logic            writes;
      logic            reads_rd;
      logic            reads_rs;
   } decode_t;

   function automatic decode_t decode_instr(input logic [INSTR_W-1:0] instr);
      decode_t d;
      logic    is_nop;
      d.op       = instr[OP_MSB -: 8];
      d.rd       = instr[RD_MSB -: REG_W];
      d.rs       = instr[RS_MSB -: REG_W];
      d.imm      = instr[IMM_MSB:0];
      is_nop     = (d.op == OP_NOP);
      d.writes   = !is_nop && !d.op[OPF_NOWRITE] && (d.rd != '0);
      d.reads_rd = !is_nop && d.op[OPF_READ_RD];
      d.reads_rs = !is_nop && d.op[OPF_READ_RS];
      return d;
   endfunction

   function automatic logic shadow_hit(input shadow_t s, input reg_id_t src);
      return s.valid && (s.regnum == src);
   endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// Fetch/decode/execute/writeback signals seen by the stage-2 decode block.
// slave = the decode block, master = whoever drives fetch and writeback.
interface cpu_decode_if;
   import cpu_pkg::*;

   logic [INSTR_W-1:0] instruction_1a;
   logic [XLEN-1:0]    pc_1a;
   logic               kill_4a;
   logic               wb_en_5a;
   reg_id_t            wb_reg_5a;
   logic [XLEN-1:0]    wb_data_5a;

   logic               stall_2a;
   logic               valid_2a;
   logic [XLEN-1:0]    pc_2a;
   logic [7:0]         opcode_2a;
   reg_id_t            rd_2a;
   logic [XLEN-1:0]    imm_2a;
   logic [XLEN-1:0]    rs_val_2a;
   logic [XLEN-1:0]    rd_val_2a;
   logic               writes_2a;

   modport slave (
      input  instruction_1a, pc_1a, kill_4a, wb_en_5a, wb_reg_5a, wb_data_5a,
      output stall_2a, valid_2a, pc_2a, opcode_2a, rd_2a, imm_2a,
             rs_val_2a, rd_val_2a, writes_2a
   );

   modport master (
      output instruction_1a, pc_1a, kill_4a, wb_en_5a, wb_reg_5a, wb_data_5a,
      input  stall_2a, valid_2a, pc_2a, opcode_2a, rd_2a, imm_2a,
             rs_val_2a, rd_val_2a, writes_2a
   );

endinterface

// File: rtl/cpu_regfile.sv
// 16x32 register file: two combinational read ports, one write port, r0 reads 0.
// With CPU_DECODE_WB_BYPASS_EN defined, reads forward same-cycle write data.
module cpu_regfile
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_b,
   input  logic            i_wr_en,
   input  reg_id_t         i_wr_addr,
   input  logic [XLEN-1:0] i_wr_data,
   input  reg_id_t         i_rd_addr_a,
   input  reg_id_t         i_rd_addr_b,
   output logic [XLEN-1:0] o_rd_data_a,
   output logic [XLEN-1:0] o_rd_data_b
);

   logic [XLEN-1:0] r_mem [NREGS];

   // NOTE: the array is reset because register contents must read 0 after
   // reset; a plain RAM macro without reset would not meet that.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en && (i_wr_addr != '0)) begin
         // NOTE: non-blocking so every reader in this edge sees the old value.
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // NOTE: both outputs get a default first so no path can infer a latch.
   always_comb begin
      o_rd_data_a = r_mem[i_rd_addr_a];
      o_rd_data_b = r_mem[i_rd_addr_b];
`ifdef CPU_DECODE_WB_BYPASS_EN
      if (i_wr_en && (i_wr_addr == i_rd_addr_a)) o_rd_data_a = i_wr_data;
      if (i_wr_en && (i_wr_addr == i_rd_addr_b)) o_rd_data_b = i_wr_data;
`endif
      if (i_rd_addr_a == '0) o_rd_data_a = '0;
      if (i_rd_addr_b == '0) o_rd_data_b = '0;
   end

endmodule

// File: rtl/cpu_decode.sv
// Stage-2 decode: register read, RAW hazard stall against in-flight writers,
// kill flush, registered 2a outputs. Optional macro: CPU_DECODE_WB_BYPASS_EN.
module cpu_decode
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_b,
   cpu_decode_if.slave bus
);

   decode_t         w_dec;
   logic [XLEN-1:0] w_rs_data;
   logic [XLEN-1:0] w_rd_data;
   logic            w_wb_hit_rs;
   logic            w_wb_hit_rd;
   logic            w_hit_rs;
   logic            w_hit_rd;
   logic            w_stall;
   logic            w_bubble;
   shadow_t         w_sh_new;

   shadow_t         r_sh_2a;
   shadow_t         r_sh_3a;
   shadow_t         r_sh_4a;
   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [7:0]      r_opcode;
   reg_id_t         r_rd;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_rs_val;
   logic [XLEN-1:0] r_rd_val;
   logic            r_writes;

   assign w_dec = decode_instr(bus.instruction_1a);

   cpu_regfile u_regfile (
      .clk         (clk),
      .rst_b       (rst_b),
      .i_wr_en     (bus.wb_en_5a),
      .i_wr_addr   (bus.wb_reg_5a),
      .i_wr_data   (bus.wb_data_5a),
      .i_rd_addr_a (w_dec.rs),
      .i_rd_addr_b (w_dec.rd),
      .o_rd_data_a (w_rs_data),
      .o_rd_data_b (w_rd_data)
   );

   // Without forwarding, a source being written back this cycle is not yet
   // readable, so the 5a writer extends the hazard window by one stage.
`ifdef CPU_DECODE_WB_BYPASS_EN
   assign w_wb_hit_rs = 1'b0;
   assign w_wb_hit_rd = 1'b0;
`else
   assign w_wb_hit_rs = bus.wb_en_5a && (bus.wb_reg_5a == w_dec.rs);
   assign w_wb_hit_rd = bus.wb_en_5a && (bus.wb_reg_5a == w_dec.rd);
`endif

   assign w_hit_rs = (w_dec.rs != '0) &&
                     (shadow_hit(r_sh_2a, w_dec.rs) || shadow_hit(r_sh_3a, w_dec.rs) ||
                      shadow_hit(r_sh_4a, w_dec.rs) || w_wb_hit_rs);
   assign w_hit_rd = (w_dec.rd != '0) &&
                     (shadow_hit(r_sh_2a, w_dec.rd) || shadow_hit(r_sh_3a, w_dec.rd) ||
                      shadow_hit(r_sh_4a, w_dec.rd) || w_wb_hit_rd);

   // Kill outranks stall: the stalled instruction is on the wrong path anyway.
   assign w_stall  = !bus.kill_4a &&
                     ((w_dec.reads_rs && w_hit_rs) || (w_dec.reads_rd && w_hit_rd));
   assign w_bubble = bus.kill_4a || w_stall;

   assign w_sh_new.valid  = w_dec.writes;
   assign w_sh_new.regnum = w_dec.rd;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_sh_2a  <= '0;
         r_sh_3a  <= '0;
         r_sh_4a  <= '0;
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_opcode <= '0;
         r_rd     <= '0;
         r_imm    <= '0;
         r_rs_val <= '0;
         r_rd_val <= '0;
         r_writes <= 1'b0;
      end else begin
         r_sh_4a <= r_sh_3a;
         r_sh_3a <= bus.kill_4a ? '0 : r_sh_2a;
         if (w_bubble) begin
            r_sh_2a  <= '0;
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_opcode <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_rs_val <= '0;
            r_rd_val <= '0;
            r_writes <= 1'b0;
         end else begin
            r_sh_2a  <= w_sh_new;
            r_valid  <= (w_dec.op != OP_NOP);
            r_pc     <= bus.pc_1a;
            r_opcode <= w_dec.op;
            r_rd     <= w_dec.rd;
            r_imm    <= w_dec.imm;
            r_rs_val <= w_rs_data;
            r_rd_val <= w_rd_data;
            r_writes <= w_dec.writes;
         end
      end
   end

   assign bus.stall_2a  = w_stall;
   assign bus.valid_2a  = r_valid;
   assign bus.pc_2a     = r_pc;
   assign bus.opcode_2a = r_opcode;
   assign bus.rd_2a     = r_rd;
   assign bus.imm_2a    = r_imm;
   assign bus.rs_val_2a = r_rs_val;
   assign bus.rd_val_2a = r_rd_val;
   assign bus.writes_2a = r_writes;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: decode vector table, then stall, kill and
// reset sequences. Expected stall length depends on CPU_DECODE_WB_BYPASS_EN.
module tb_cpu_decode;

   logic clk;
   logic rst_b;
   int   n_tests;
   int   n_fail;

   cpu_decode_if bus ();

   cpu_decode dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CPU_DECODE_WB_BYPASS_EN
   localparam int EXP_STALLS = 3;
`else
   localparam int EXP_STALLS = 4;
`endif

   localparam logic [47:0] W5 = {8'h01, 4'h5, 4'h0, 32'h0};
   localparam logic [47:0] R5 = {8'h20, 4'h0, 4'h5, 32'h0};

   typedef struct {
      logic [47:0] instr;
      logic [31:0] pc;
      logic        wb_en;
      logic [3:0]  wb_reg;
      logic [31:0] wb_data;
      logic        exp_valid;
      logic        exp_writes;
      logic [31:0] exp_rs;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [47:0] instr, input logic [31:0] pc);
      bus.instruction_1a = instr;
      bus.pc_1a          = pc;
      bus.kill_4a        = 1'b0;
      bus.wb_en_5a       = 1'b0;
      bus.wb_reg_5a      = 4'h0;
      bus.wb_data_5a     = 32'h0;
   endtask

   task automatic nops(input int n);
      drive(48'h0, 32'h0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " stall"},  32'(bus.stall_2a),  32'h0);
      check({tag, " valid"},  32'(bus.valid_2a),  32'h0);
      check({tag, " writes"}, 32'(bus.writes_2a), 32'h0);
      check({tag, " pc"},     bus.pc_2a,          32'h0);
      check({tag, " opcode"}, 32'(bus.opcode_2a), 32'h0);
      check({tag, " rd"},     32'(bus.rd_2a),     32'h0);
      check({tag, " imm"},    bus.imm_2a,         32'h0);
      check({tag, " rs_val"}, bus.rs_val_2a,      32'h0);
      check({tag, " rd_val"}, bus.rd_val_2a,      32'h0);
   endtask

   initial begin
      int  n_stall;
      bit  done;
      logic [47:0] ins;

      n_tests = 0;
      n_fail  = 0;
      rst_b   = 1'b0;
      drive(48'h0, 32'h0);

      //                instr                                pc      wb  reg   wb_data      val wr  rs            rd
      vecs[0]  = '{48'h0,                               32'h100, 0, 4'h0, 32'h0,        0, 0, 32'h0,        32'h0};
      vecs[1]  = '{48'h0,                               32'h104, 1, 4'h3, 32'h1234,     0, 0, 32'h0,        32'h0};
      vecs[2]  = '{48'h0,                               32'h108, 0, 4'h0, 32'h0,        0, 0, 32'h0,        32'h0};
      vecs[3]  = '{{8'h20, 4'h0, 4'h3, 32'h0},          32'h10C, 0, 4'h0, 32'h0,        1, 0, 32'h1234,     32'h0};
      vecs[4]  = '{48'h0,                               32'h110, 1, 4'h7, 32'hCAFE0007, 0, 0, 32'h0,        32'h0};
      vecs[5]  = '{{8'h61, 4'h7, 4'h3, 32'hDEADBEEF},   32'h114, 0, 4'h0, 32'h0,        1, 1, 32'h1234,     32'hCAFE0007};
      vecs[6]  = '{{8'h80, 4'h5, 4'h3, 32'h5},          32'h118, 0, 4'h0, 32'h0,        1, 0, 32'h1234,     32'h0};
      vecs[7]  = '{{8'h01, 4'h0, 4'h0, 32'h0},          32'h11C, 0, 4'h0, 32'h0,        1, 0, 32'h0,        32'h0};
      vecs[8]  = '{{8'h60, 4'h0, 4'h0, 32'h0},          32'h120, 0, 4'h0, 32'h0,        1, 0, 32'h0,        32'h0};
      vecs[9]  = '{{8'h40, 4'h3, 4'h0, 32'hFF},         32'h124, 0, 4'h0, 32'h0,        1, 1, 32'h0,        32'h1234};
      vecs[10] = '{{8'hA0, 4'h9, 4'h7, 32'h0},          32'h128, 1, 4'h0, 32'hFFFFFFFF, 1, 0, 32'hCAFE0007, 32'h0};
      vecs[11] = '{{8'h20, 4'h0, 4'h0, 32'h0},          32'h12C, 0, 4'h0, 32'h0,        1, 0, 32'h0,        32'h0};

      #12;
      check_all_zero("reset");
      #1 rst_b = 1'b1;
      tick();
      check_all_zero("nop after reset");

      for (int i = 0; i < 12; i++) begin
         ins = vecs[i].instr;
         drive(ins, vecs[i].pc);
         bus.wb_en_5a   = vecs[i].wb_en;
         bus.wb_reg_5a  = vecs[i].wb_reg;
         bus.wb_data_5a = vecs[i].wb_data;
         #2;
         check($sformatf("vec%0d stall", i), 32'(bus.stall_2a), 32'h0);
         tick();
         check($sformatf("vec%0d valid", i),  32'(bus.valid_2a),  32'(vecs[i].exp_valid));
         check($sformatf("vec%0d writes", i), 32'(bus.writes_2a), 32'(vecs[i].exp_writes));
         check($sformatf("vec%0d opcode", i), 32'(bus.opcode_2a), 32'(ins[47:40]));
         check($sformatf("vec%0d rd", i),     32'(bus.rd_2a),     32'(ins[39:36]));
         check($sformatf("vec%0d imm", i),    bus.imm_2a,         ins[31:0]);
         check($sformatf("vec%0d pc", i),     bus.pc_2a,          vecs[i].pc);
         check($sformatf("vec%0d rs_val", i), bus.rs_val_2a,      vecs[i].exp_rs);
         check($sformatf("vec%0d rd_val", i), bus.rd_val_2a,      vecs[i].exp_rd);
      end

      // Writer of r5 then dependent reader: writeback driven when the writer reaches 5a.
      nops(4);
      drive(W5, 32'h200);
      tick();
      check("A writer writes", 32'(bus.writes_2a), 32'h1);
      drive(R5, 32'h204);
      n_stall = 0;
      done    = 1'b0;
      for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
         bus.wb_en_5a   = (cyc == 4);
         bus.wb_reg_5a  = 4'h5;
         bus.wb_data_5a = 32'h5555AAAA;
         #2;
         if (bus.stall_2a) begin
            n_stall++;
            tick();
            check("A bubble valid", 32'(bus.valid_2a), 32'h0);
            check("A bubble pc",    bus.pc_2a,         32'h0);
         end else begin
            tick();
            check("A reader valid",  32'(bus.valid_2a), 32'h1);
            check("A reader rs_val", bus.rs_val_2a,     32'h5555AAAA);
            done = 1'b1;
         end
      end
      check("A reader issued", 32'(done), 32'h1);
      check("A stall cycles",  32'(n_stall), 32'(EXP_STALLS));

      // Kill while the r5 writer sits in 2a: it is flushed, reader proceeds.
      nops(4);
      drive(W5, 32'h300);
      tick();
      drive(R5, 32'h304);
      #2;
      check("B stall before kill", 32'(bus.stall_2a), 32'h1);
      bus.kill_4a = 1'b1;
      #1;
      check("B stall under kill", 32'(bus.stall_2a), 32'h0);
      tick();
      check("B kill bubble valid",  32'(bus.valid_2a),  32'h0);
      check("B kill bubble writes", 32'(bus.writes_2a), 32'h0);
      drive(R5, 32'h400);
      #2;
      check("B reader after kill stall", 32'(bus.stall_2a), 32'h0);
      tick();
      check("B reader after kill valid", 32'(bus.valid_2a), 32'h1);
      check("B reader rs_val",           bus.rs_val_2a,     32'h5555AAAA);

      // Kill while the writer is in 3a: it shifts into 4a and still blocks one cycle.
      nops(4);
      drive(W5, 32'h500);
      tick();
      drive(R5, 32'h504);
      #2;
      check("C stall writer 2a", 32'(bus.stall_2a), 32'h1);
      tick();
      bus.kill_4a = 1'b1;
      #2;
      check("C stall under kill", 32'(bus.stall_2a), 32'h0);
      tick();
      check("C kill bubble valid", 32'(bus.valid_2a), 32'h0);
      drive(R5, 32'h600);
      #2;
      check("C stall writer 4a", 32'(bus.stall_2a), 32'h1);
      tick();
      check("C bubble valid", 32'(bus.valid_2a), 32'h0);
      #2;
      check("C stall cleared", 32'(bus.stall_2a), 32'h0);
      tick();
      check("C reader valid", 32'(bus.valid_2a), 32'h1);
      check("C reader pc",    bus.pc_2a,         32'h600);

      // Asynchronous reset in the middle of a stall.
      nops(4);
      drive(W5, 32'h700);
      tick();
      check("D writer valid", 32'(bus.valid_2a), 32'h1);
      drive(R5, 32'h704);
      #2;
      check("D stall before reset", 32'(bus.stall_2a), 32'h1);
      rst_b = 1'b0;
      #1;
      check_all_zero("D async reset");
      #3 rst_b = 1'b1;
      #1;
      check("D stall after release", 32'(bus.stall_2a), 32'h0);
      tick();
      check("D reader valid",  32'(bus.valid_2a), 32'h1);
      check("D reader rs_val", bus.rs_val_2a,     32'h0);
      check("D reader pc",     bus.pc_2a,         32'h704);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

endmodule
